// File: rtl/gpup_pkg.sv
// Shared definitions for the posit vector processor command issuer: opcodes, issuer
// states and error-flag bit positions.
package gpup_pkg;

    localparam logic [3:0] OP_LOAD     = 4'b0001;
    localparam logic [3:0] OP_STORE    = 4'b0010;
    localparam logic [3:0] OP_ADD      = 4'b0011;
    localparam logic [3:0] OP_SUB      = 4'b0100;
    localparam logic [3:0] OP_MUL      = 4'b0101;
    localparam logic [3:0] OP_BLOCKDIM = 4'b0110;
    localparam logic [3:0] OP_GBWR     = 4'b0111;
    localparam logic [3:0] OP_GBRD     = 4'b1000;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } issuer_state_e;

    localparam int unsigned ERR_TIMEOUT  = 0;
    localparam int unsigned ERR_ILLEGAL  = 1;
    localparam int unsigned ERR_SPURIOUS = 2;

    function automatic logic op_legal(input logic [3:0] op);
        return op inside {OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_MUL, OP_BLOCKDIM, OP_GBWR,
                          OP_GBRD};
    endfunction

endpackage

// File: rtl/gpup_cmd_fifo.sv
// Show-ahead command FIFO, 32-bit entries; a push is accepted while full when a pop
// happens in the same cycle.
module gpup_cmd_fifo #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic [31:0] wdata_i,
    input  logic        pop_i,
    output logic [31:0] rdata_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once count_q covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/gpup_cmd_issuer.sv
// Command bus initiator: buffers host commands and issues them one at a time to the
// posit processor. Optional perf counters under `GPUP_ISSUER_PERF_EN.
module gpup_cmd_issuer
    import gpup_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] cmd_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        gpup_req_o,
    output logic [31:0] gpup_addr_o,
    output logic [31:0] gpup_wdata_o,
    input  logic        gpup_rvalid_i,
    input  logic [31:0] gpup_rdata_i,
    output logic        busy_o,
    output logic [2:0]  err_o,
`ifdef GPUP_ISSUER_PERF_EN
    output logic [31:0] perf_cmds_o,
    output logic [31:0] perf_wait_o,
`endif
    input  logic        err_clr_i
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    issuer_state_e state_q, state_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          req_q, req_d;
    logic          is_rd_q, is_rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic [2:0]    err_q, err_d;

    logic [31:0]   fifo_head;
    logic          fifo_full, fifo_empty, fifo_pop;
    logic [3:0]    head_op;
    logic          complete;
    logic          unused_rdata_hi;

    gpup_cmd_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (cmd_valid_i),
        .wdata_i(cmd_data_i),
        .pop_i  (fifo_pop),
        .rdata_o(fifo_head),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign head_op         = fifo_head[31:28];
    assign unused_rdata_hi = ^gpup_rdata_i[31:16];

    always_comb begin
        state_d     = state_q;
        wdata_d     = wdata_q;
        req_d       = 1'b0;
        is_rd_d     = is_rd_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q && !rsp_ready_i;
        rsp_data_d  = rsp_data_q;
        err_d       = err_clr_i ? 3'b000 : err_q;
        fifo_pop    = 1'b0;
        complete    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (gpup_rvalid_i) err_d[ERR_SPURIOUS] = 1'b1;
                if (!fifo_empty) begin
                    if (!op_legal(head_op)) begin
                        fifo_pop           = 1'b1;
                        err_d[ERR_ILLEGAL] = 1'b1;
                    end else if (!(head_op == OP_GBRD && rsp_valid_q)) begin
                        fifo_pop = 1'b1;
                        wdata_d  = fifo_head;
                        req_d    = 1'b1;
                        is_rd_d  = (head_op == OP_GBRD);
                        state_d  = StIssue;
                    end
                end
            end
            StIssue: begin
                cnt_d = '0;
                if (gpup_rvalid_i) complete = 1'b1;
                else               state_d  = StWait;
            end
            StWait: begin
                if (gpup_rvalid_i) begin
                    complete = 1'b1;
                end else if (cnt_q == TO_LAST) begin
                    err_d[ERR_TIMEOUT] = 1'b1;
                    state_d            = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A held result never collides with a new one: reads wait in IDLE while one is held.
        if (complete) begin
            state_d = StIdle;
            if (is_rd_q) begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = {16'h0000, gpup_rdata_i[15:0]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            wdata_q     <= '0;
            req_q       <= 1'b0;
            is_rd_q     <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            wdata_q     <= wdata_d;
            req_q       <= req_d;
            is_rd_q     <= is_rd_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
        end
    end

`ifdef GPUP_ISSUER_PERF_EN
    logic [31:0] perf_cmds_q, perf_cmds_d;
    logic [31:0] perf_wait_q, perf_wait_d;

    always_comb begin
        perf_cmds_d = perf_cmds_q + {31'd0, complete};
        perf_wait_d = perf_wait_q + {31'd0, (state_q == StWait)};
        if (err_clr_i) begin
            perf_cmds_d = '0;
            perf_wait_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cmds_q <= '0;
            perf_wait_q <= '0;
        end else begin
            perf_cmds_q <= perf_cmds_d;
            perf_wait_q <= perf_wait_d;
        end
    end

    assign perf_cmds_o = perf_cmds_q;
    assign perf_wait_o = perf_wait_q;
`endif

    assign cmd_ready_o  = !fifo_full || fifo_pop;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign gpup_req_o   = req_q;
    assign gpup_addr_o  = BASE_ADDR;
    assign gpup_wdata_o = wdata_q;
    assign busy_o       = !fifo_empty || (state_q != StIdle);
    assign err_o        = err_q;

endmodule

// File: tb/tb_gpup_cmd_issuer.sv
// Scoreboard bench for gpup_cmd_issuer: issued commands and returned results are
// checked by monitors against queues filled by the directed stimulus.
module tb_gpup_cmd_issuer;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid_i, cmd_ready_o;
    logic [31:0] cmd_data_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        gpup_req_o;
    logic [31:0] gpup_addr_o, gpup_wdata_o;
    logic        gpup_rvalid_i;
    logic [31:0] gpup_rdata_i;
    logic        busy_o;
    logic [2:0]  err_o;
    logic        err_clr_i;

    int n_cmp = 0;
    int n_err = 0;
    int req_seen = 0;

    logic [31:0] exp_req[$];
    logic [31:0] exp_rsp[$];
    logic [31:0] model_rdata_q[$];
    int          model_delay;
    bit          model_silent;

    always #5 clk = ~clk;

    gpup_cmd_issuer #(
        .FIFO_DEPTH    (4),
        .TIMEOUT_CYCLES(16),
        .BASE_ADDR     (BASE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_data_i   (cmd_data_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_data_o   (rsp_data_o),
        .gpup_req_o   (gpup_req_o),
        .gpup_addr_o  (gpup_addr_o),
        .gpup_wdata_o (gpup_wdata_o),
        .gpup_rvalid_i(gpup_rvalid_i),
        .gpup_rdata_i (gpup_rdata_i),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .err_clr_i    (err_clr_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cmd_ready"}, {31'd0, cmd_ready_o}, 32'd1);
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid_o}, 32'd0);
        check({tag, "_rsp_data"}, rsp_data_o, 32'd0);
        check({tag, "_req"}, {31'd0, gpup_req_o}, 32'd0);
        check({tag, "_addr"}, gpup_addr_o, BASE);
        check({tag, "_wdata"}, gpup_wdata_o, 32'd0);
        check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_err"}, {29'd0, err_o}, 32'd0);
    endtask

    // Processor model: one rvalid pulse model_delay cycles after the req cycle.
    initial begin
        logic [31:0] rd;
        gpup_rvalid_i = 1'b0;
        gpup_rdata_i  = '0;
        forever begin
            @(negedge clk);
            if (rst && gpup_req_o && !model_silent) begin
                if (model_rdata_q.size() != 0) rd = model_rdata_q.pop_front();
                else                           rd = 32'h0;
                repeat (model_delay) @(posedge clk);
                #1;
                gpup_rvalid_i = 1'b1;
                gpup_rdata_i  = rd;
                @(posedge clk);
                #1;
                gpup_rvalid_i = 1'b0;
                gpup_rdata_i  = '0;
            end
        end
    end

    // Monitor: every issued command must be the next expected one.
    always @(negedge clk) begin
        if (rst && gpup_req_o) begin
            req_seen++;
            if (exp_req.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL req_unexpected: wdata %h issued, none expected", gpup_wdata_o);
            end else begin
                check("req_wdata", gpup_wdata_o, exp_req.pop_front());
            end
        end
    end

    // Monitor: every consumed result must be the next expected one.
    always @(negedge clk) begin
        if (rst && rsp_valid_o && rsp_ready_i) begin
            if (exp_rsp.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rsp_unexpected: data %h returned, none expected", rsp_data_o);
            end else begin
                check("rsp_data", rsp_data_o, exp_rsp.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        bit done = 1'b0;
        cmd_valid_i = 1'b1;
        cmd_data_i  = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = cmd_ready_o;
            @(posedge clk);
            #1;
        end
        cmd_valid_i = 1'b0;
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL push_accept: cmd %h not accepted, expected accept within 50 cycles", d);
        end
    endtask

    // Leaves the caller at the negedge on which rvalid is seen.
    task automatic wait_rvalid(input int max, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (gpup_rvalid_i) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s: rvalid absent, expected within %0d cycles", name, max);
        end
    endtask

    task automatic wait_idle(input int max, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (!busy_o && !rsp_valid_o) seen = 1'b1;
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s: still busy, expected idle within %0d cycles", name, max);
        end
    endtask

    initial begin
        int r0;
        int lat;
        bit seen;
        rst          = 1'b0;
        cmd_valid_i  = 1'b0;
        cmd_data_i   = '0;
        rsp_ready_i  = 1'b0;
        err_clr_i    = 1'b0;
        model_delay  = 3;
        model_silent = 1'b0;

        step(2);
        check_reset("reset");
        rst = 1'b1;
        step(1);

        // 1: non-read command, completion 3 cycles after req.
        exp_req.push_back(32'h7030_1234);
        push(32'h7030_1234);
        wait_rvalid(20, "t1_rvalid");
        check("t1_busy_at_rvalid", {31'd0, busy_o}, 32'd1);
        @(negedge clk);
        check("t1_busy_after", {31'd0, busy_o}, 32'd0);
        check("t1_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        step(1);

        // 2: read returns low half of rdata, held until consumed.
        model_rdata_q.push_back(32'hDEAD_3C00);
        exp_req.push_back(32'h8000_0005);
        exp_rsp.push_back(32'h0000_3C00);
        push(32'h8000_0005);
        wait_rvalid(20, "t2_rvalid");
        step(3);
        check("t2_rsp_valid_held", {31'd0, rsp_valid_o}, 32'd1);
        check("t2_rsp_data_held", rsp_data_o, 32'h0000_3C00);
        rsp_ready_i = 1'b1;
        step(1);
        rsp_ready_i = 1'b0;
        check("t2_rsp_valid_cleared", {31'd0, rsp_valid_o}, 32'd0);

        // 3: second read waits for the first result to be consumed.
        model_delay = 2;
        model_rdata_q.push_back(32'h1234_0001);
        model_rdata_q.push_back(32'hFFFF_8002);
        exp_req.push_back(32'h8000_0001);
        exp_req.push_back(32'h8000_0002);
        exp_rsp.push_back(32'h0000_0001);
        exp_rsp.push_back(32'h0000_8002);
        push(32'h8000_0001);
        push(32'h8000_0002);
        wait_rvalid(20, "t3_rvalid");
        r0 = req_seen;
        step(6);
        check("t3_no_second_req", req_seen, r0);
        check("t3_rsp_valid_held", {31'd0, rsp_valid_o}, 32'd1);
        check("t3_busy_holding", {31'd0, busy_o}, 32'd1);
        rsp_ready_i = 1'b1;
        wait_idle(40, "t3_idle");
        rsp_ready_i = 1'b0;
        check("t3_second_req", req_seen, r0 + 1);

        // 4: illegal opcode dropped, next command issued.
        model_delay = 3;
        r0 = req_seen;
        exp_req.push_back(32'h6000_0008);
        push(32'h9000_0000);
        push(32'h6000_0008);
        wait_idle(40, "t4_idle");
        check("t4_err_illegal", {29'd0, err_o}, 32'd2);
        check("t4_req_count", req_seen, r0 + 1);
        err_clr_i = 1'b1;
        step(1);
        err_clr_i = 1'b0;
        check("t4_err_cleared", {29'd0, err_o}, 32'd0);

        // 5: timeout after 16 WAIT cycles, late rvalid flagged spurious.
        model_delay = 22;
        exp_req.push_back(32'h1000_0000);
        push(32'h1000_0000);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (gpup_req_o) seen = 1'b1;
        end
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(negedge clk);
            if (err_o[0]) lat = i;
        end
        // req cycle is the ISSUE cycle; WAIT starts one cycle later.
        check("t5_timeout_latency", lat, 17);
        check("t5_err_timeout", {29'd0, err_o}, 32'd1);
        check("t5_busy_after_timeout", {31'd0, busy_o}, 32'd0);
        wait_rvalid(20, "t5_late_rvalid");
        @(negedge clk);
        check("t5_err_spurious", {29'd0, err_o}, 32'd5);
        step(1);
        push(32'hF000_0000);
        err_clr_i = 1'b1;
        step(1);
        err_clr_i = 1'b0;
        check("t5_clr_vs_new_event", {29'd0, err_o}, 32'd2);
        err_clr_i = 1'b1;
        step(1);
        err_clr_i = 1'b0;
        check("t5_err_cleared", {29'd0, err_o}, 32'd0);

        // 6: stalled processor fills the FIFO; async reset mid-WAIT.
        model_silent = 1'b1;
        exp_req.push_back(32'h1000_0001);
        push(32'h1000_0001);
        push(32'h1000_0002);
        push(32'h1000_0003);
        push(32'h1000_0004);
        push(32'h1000_0005);
        check("t6_ready_full", {31'd0, cmd_ready_o}, 32'd0);
        check("t6_busy_full", {31'd0, busy_o}, 32'd1);
        step(3);
        r0 = req_seen;
        #2;
        rst = 1'b0;
        #1;
        check_reset("t6_async_reset");
        step(2);
        rst = 1'b1;
        step(4);
        check("t6_no_req_after_reset", req_seen, r0);
        check("t6_idle_after_reset", {31'd0, busy_o}, 32'd0);

        check("req_queue_drained", exp_req.size(), 32'd0);
        check("rsp_queue_drained", exp_rsp.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
